// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stall/jump/interrupt requests in, stall vector,
// flushes, PC redirect and interrupt status out. Port suffixes follow the controller's view.
interface pipe_ctrl_if #(parameter int ADDR_WIDTH = 32);
  logic                  stallreq_if_i;
  logic                  stallreq_id_i;
  logic                  stallreq_ex_i;
  logic                  stallreq_mem_i;
  logic                  jump_req_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;
  logic                  int_req_i;
  logic [ADDR_WIDTH-1:0] int_vector_i;
  logic [ADDR_WIDTH-1:0] pc_i;
  logic [ADDR_WIDTH-1:0] id_inst_addr_i;
  logic [ADDR_WIDTH-1:0] ex_inst_addr_i;
  logic [5:0]            stall_o;
  logic                  flush_jump_o;
  logic                  flush_int_o;
  logic                  redirect_o;
  logic [ADDR_WIDTH-1:0] redirect_addr_o;
  logic                  int_ack_o;
  logic [ADDR_WIDTH-1:0] epc_o;

  // Handshake: no valid/ready pairs. Requests are levels sampled every cycle;
  // stall/flush/redirect respond in the same cycle, int_ack_o is a single-cycle pulse.
  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output jump_req_i, jump_addr_i, int_req_i, int_vector_i,
    output pc_i, id_inst_addr_i, ex_inst_addr_i,
    input  stall_o, flush_jump_o, flush_int_o, redirect_o, redirect_addr_o,
    input  int_ack_o, epc_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  jump_req_i, jump_addr_i, int_req_i, int_vector_i,
    input  pc_i, id_inst_addr_i, ex_inst_addr_i,
    output stall_o, flush_jump_o, flush_int_o, redirect_o, redirect_addr_o,
    output int_ack_o, epc_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall vector, jump flush/redirect and
// interrupt entry. The interrupt FSM and EPC exist only with PIPE_CTRL_INT_EN.
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pipe_ctrl_if.slave ctrl,
  output logic [1:0] int_state_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  logic [5:0] stall_base;
  logic       jump_ok;

  // The deepest stalling stage freezes itself and everything upstream of it.
  always_comb begin
    stall_base = 6'b000000;
    if (ctrl.stallreq_mem_i)     stall_base = 6'b011111;
    else if (ctrl.stallreq_ex_i) stall_base = 6'b001111;
    else if (ctrl.stallreq_id_i) stall_base = 6'b000111;
    else if (ctrl.stallreq_if_i) stall_base = 6'b000011;
  end

  assign jump_ok = ctrl.jump_req_i & ~ctrl.stallreq_ex_i & ~ctrl.stallreq_mem_i;
  assign ctrl.flush_jump_o = jump_ok;

`ifdef PIPE_CTRL_INT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENTER = 2'd2,
    ST_HOLD  = 2'd3
  } int_state_e;

  int_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic                  busy;
  logic                  in_drain;
  logic                  in_enter;

  assign busy = ctrl.stallreq_ex_i | ctrl.stallreq_mem_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      epc_q   <= ZERO_ADDR;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    in_drain = 1'b0;
    in_enter = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl.int_req_i) state_d = busy ? ST_DRAIN : ST_ENTER;
      end
      ST_DRAIN: begin
        in_drain = 1'b1;
        if (!ctrl.int_req_i) state_d = ST_IDLE;
        else if (!busy)      state_d = ST_ENTER;
      end
      ST_ENTER: begin
        in_enter = 1'b1;
        state_d  = ST_HOLD;
        // Return address is the oldest instruction that has not completed.
        if (ctrl.jump_req_i)                      epc_d = ctrl.jump_addr_i;
        else if (ctrl.ex_inst_addr_i != ZERO_ADDR) epc_d = ctrl.ex_inst_addr_i;
        else if (ctrl.id_inst_addr_i != ZERO_ADDR) epc_d = ctrl.id_inst_addr_i;
        else                                       epc_d = ctrl.pc_i;
      end
      ST_HOLD: begin
        if (!ctrl.int_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ctrl.stall_o         = stall_base | (in_drain ? 6'b000011 : 6'b000000);
  assign ctrl.flush_int_o     = in_enter;
  assign ctrl.int_ack_o       = in_enter;
  assign ctrl.redirect_o      = in_enter | jump_ok;
  assign ctrl.redirect_addr_o = in_enter ? ctrl.int_vector_i : ctrl.jump_addr_i;
  assign ctrl.epc_o           = epc_q;
  assign int_state_o          = state_q;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ^{clk_i, rst_i, ctrl.int_req_i, ctrl.int_vector_i,
                               ctrl.pc_i, ctrl.id_inst_addr_i, ctrl.ex_inst_addr_i};

  assign ctrl.stall_o         = stall_base;
  assign ctrl.flush_int_o     = 1'b0;
  assign ctrl.int_ack_o       = 1'b0;
  assign ctrl.redirect_o      = jump_ok;
  assign ctrl.redirect_addr_o = ctrl.jump_addr_i;
  assign ctrl.epc_o           = ZERO_ADDR;
  assign int_state_o          = 2'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus random traffic compared
// every cycle against an event-level interrupt model.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dbg_state;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          cmp_en = 1'b0;

  pipe_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  pipe_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .ctrl        (bus),
    .int_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit          m_wait, m_enter, m_hold;
  logic [31:0] m_epc;
  logic [31:0] exp_q[$];

  function automatic logic [5:0] stall_mask(logic f, logic d, logic e, logic m);
    int top;
    top = m ? 4 : e ? 3 : d ? 2 : f ? 1 : 0;
    if (top == 0) return 6'd0;
    return 6'((1 << (top + 1)) - 1);
  endfunction

  function automatic logic [31:0] epc_pick(logic jr, logic [31:0] ja, logic [31:0] ex,
                                           logic [31:0] id, logic [31:0] pc);
    if (jr) return ja;
    if (ex != 0) return ex;
    if (id != 0) return id;
    return pc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait  <= 1'b0;
      m_enter <= 1'b0;
      m_hold  <= 1'b0;
      m_epc   <= 32'd0;
      exp_q.delete();
    end else if (m_enter) begin
      m_enter <= 1'b0;
      m_hold  <= 1'b1;
      m_epc   <= epc_pick(bus.jump_req_i, bus.jump_addr_i, bus.ex_inst_addr_i,
                          bus.id_inst_addr_i, bus.pc_i);
      exp_q.push_back(epc_pick(bus.jump_req_i, bus.jump_addr_i, bus.ex_inst_addr_i,
                               bus.id_inst_addr_i, bus.pc_i));
    end else if (m_hold) begin
      if (!bus.int_req_i) m_hold <= 1'b0;
    end else if (m_wait) begin
      if (!bus.int_req_i) m_wait <= 1'b0;
      else if (!(bus.stallreq_ex_i | bus.stallreq_mem_i)) begin
        m_wait  <= 1'b0;
        m_enter <= 1'b1;
      end
    end else if (INT_EN && bus.int_req_i) begin
      if (bus.stallreq_ex_i | bus.stallreq_mem_i) m_wait <= 1'b1;
      else m_enter <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic        jok;
      logic [5:0]  e_stall;
      jok     = bus.jump_req_i & ~bus.stallreq_ex_i & ~bus.stallreq_mem_i;
      e_stall = stall_mask(bus.stallreq_if_i, bus.stallreq_id_i, bus.stallreq_ex_i,
                           bus.stallreq_mem_i) | (m_wait ? 6'b000011 : 6'b000000);
      chk("m_stall", 32'(bus.stall_o), 32'(e_stall));
      chk("m_flush_jump", 32'(bus.flush_jump_o), 32'(jok));
      chk("m_flush_int", 32'(bus.flush_int_o), 32'(m_enter));
      chk("m_int_ack", 32'(bus.int_ack_o), 32'(m_enter));
      chk("m_redirect", 32'(bus.redirect_o), 32'(m_enter | jok));
      if (m_enter | jok)
        chk("m_redir_addr", bus.redirect_addr_o, m_enter ? bus.int_vector_i : bus.jump_addr_i);
      chk("m_epc", bus.epc_o, m_epc);
      if (exp_q.size() > 0) chk("m_epc_q", bus.epc_o, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.stallreq_if_i  = 1'b0;
    bus.stallreq_id_i  = 1'b0;
    bus.stallreq_ex_i  = 1'b0;
    bus.stallreq_mem_i = 1'b0;
    bus.jump_req_i     = 1'b0;
    bus.jump_addr_i    = 32'd0;
    bus.int_req_i      = 1'b0;
    bus.int_vector_i   = 32'd0;
    bus.pc_i           = 32'd0;
    bus.id_inst_addr_i = 32'd0;
    bus.ex_inst_addr_i = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
  endfunction

  task automatic drive_random();
    bus.stallreq_if_i  = ($urandom_range(0, 3) == 0);
    bus.stallreq_id_i  = ($urandom_range(0, 4) == 0);
    bus.stallreq_ex_i  = ($urandom_range(0, 4) == 0);
    bus.stallreq_mem_i = ($urandom_range(0, 4) == 0);
    bus.jump_req_i     = ($urandom_range(0, 3) == 0);
    bus.jump_addr_i    = rand_addr();
    if ($urandom_range(0, 7) == 0) bus.int_req_i = ~bus.int_req_i;
    bus.int_vector_i   = rand_addr();
    bus.pc_i           = rand_addr();
    bus.id_inst_addr_i = rand_addr();
    bus.ex_inst_addr_i = rand_addr();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_epc", bus.epc_o, 32'h0);
    chk("rst_flush_int", 32'(bus.flush_int_o), 32'h0);
    chk("rst_redirect", 32'(bus.redirect_o), 32'h0);
    rst_n = 1'b1;
    step();

    bus.stallreq_id_i = 1'b1; bus.stallreq_mem_i = 1'b1; settle();
    chk("stall_id_mem", 32'(bus.stall_o), 32'h1f);
    step();
    bus.stallreq_id_i = 1'b0; bus.stallreq_mem_i = 1'b0; bus.stallreq_if_i = 1'b1; settle();
    chk("stall_if", 32'(bus.stall_o), 32'h03);
    step();
    bus.stallreq_if_i = 1'b0; bus.stallreq_ex_i = 1'b1; settle();
    chk("stall_ex", 32'(bus.stall_o), 32'h0f);
    step();

    bus.stallreq_ex_i = 1'b0; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h80; settle();
    chk("jump_flush", 32'(bus.flush_jump_o), 32'h1);
    chk("jump_redirect", 32'(bus.redirect_o), 32'h1);
    chk("jump_addr", bus.redirect_addr_o, 32'h80);
    step();
    bus.stallreq_ex_i = 1'b1; settle();
    chk("jump_ex_flush", 32'(bus.flush_jump_o), 32'h0);
    chk("jump_ex_redirect", 32'(bus.redirect_o), 32'h0);
    step();
    idle_inputs();
    step();

`ifdef PIPE_CTRL_INT_EN
    bus.ex_inst_addr_i = 32'h104; bus.int_vector_i = 32'h200; bus.int_req_i = 1'b1; settle();
    chk("int_pre_ack", 32'(bus.int_ack_o), 32'h0);
    step();
    chk("int_flush", 32'(bus.flush_int_o), 32'h1);
    chk("int_ack", 32'(bus.int_ack_o), 32'h1);
    chk("int_redirect", 32'(bus.redirect_o), 32'h1);
    chk("int_vec", bus.redirect_addr_o, 32'h200);
    step();
    chk("int_epc", bus.epc_o, 32'h104);
    for (int i = 0; i < 3; i++) begin
      chk("int_no_reack", 32'(bus.int_ack_o), 32'h0);
      step();
    end
    bus.int_req_i = 1'b0;
    step();

    idle_inputs();
    bus.int_vector_i = 32'h200; bus.id_inst_addr_i = 32'h44; bus.pc_i = 32'h48;
    bus.stallreq_mem_i = 1'b1; bus.int_req_i = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      chk("drain_mem_stall", 32'(bus.stall_o), 32'h1f);
      if (i < 2) step();
    end
    step();
    bus.stallreq_mem_i = 1'b0; settle();
    chk("drain_stall", 32'(bus.stall_o), 32'h03);
    chk("drain_no_ack", 32'(bus.int_ack_o), 32'h0);
    step();
    chk("drain_enter", 32'(bus.int_ack_o), 32'h1);
    step();
    chk("drain_epc", bus.epc_o, 32'h44);
    bus.int_req_i = 1'b0;
    step();

    bus.int_req_i = 1'b1;
    step();
    bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h300; settle();
    chk("jmpint_addr", bus.redirect_addr_o, 32'h200);
    chk("jmpint_ack", 32'(bus.int_ack_o), 32'h1);
    step();
    chk("jmpint_epc", bus.epc_o, 32'h300);
    bus.int_req_i = 1'b0; bus.jump_req_i = 1'b0;
    step();

    bus.stallreq_mem_i = 1'b1; bus.int_req_i = 1'b1;
    step();
    bus.stallreq_mem_i = 1'b0; settle();
    chk("rstdrain_pre", 32'(bus.stall_o), 32'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdrain_stall", 32'(bus.stall_o), 32'h0);
    chk("rstdrain_flush", 32'(bus.flush_int_o), 32'h0);
    chk("rstdrain_ack", 32'(bus.int_ack_o), 32'h0);
    chk("rstdrain_epc", bus.epc_o, 32'h0);
    @(posedge clk);
    #1;
    bus.int_req_i = 1'b0;
    rst_n = 1'b1;
    step();
`else
    bus.stallreq_mem_i = 1'b1; bus.int_req_i = 1'b1; bus.int_vector_i = 32'h200; settle();
    chk("noint_stall", 32'(bus.stall_o), 32'h1f);
    chk("noint_ack", 32'(bus.int_ack_o), 32'h0);
    step();
    bus.stallreq_mem_i = 1'b0; settle();
    chk("noint_stall_clr", 32'(bus.stall_o), 32'h0);
    chk("noint_redirect", 32'(bus.redirect_o), 32'h0);
    step();
    chk("noint_flush", 32'(bus.flush_int_o), 32'h0);
    chk("noint_epc", bus.epc_o, 32'h0);
    bus.int_req_i = 1'b0;
    step();
`endif

    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end
    idle_inputs();
    repeat (3) step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
